// File: rtl/regf_mem_arb_if.sv
// Bus bundle between the two requesters, the arbiter and one regf memory port.
// The slave modport is the arbiter's view of the bundle; master is the opposite side.
interface regf_mem_arb_if #(
  parameter int ADDRWIDTH = 13,
  parameter int DATAWIDTH = 32
);
  logic                 req0_ena_i;
  logic [ADDRWIDTH-1:0] req0_addr_i;
  logic                 req0_wena_i;
  logic [DATAWIDTH-1:0] req0_wdata_i;
  logic                 req0_lock_i;
  logic                 req0_gnt_o;
  logic                 req0_rvalid_o;
  logic [DATAWIDTH-1:0] req0_rdata_o;
  logic                 req0_err_o;

  logic                 req1_ena_i;
  logic [ADDRWIDTH-1:0] req1_addr_i;
  logic                 req1_wena_i;
  logic [DATAWIDTH-1:0] req1_wdata_i;
  logic                 req1_lock_i;
  logic                 req1_gnt_o;
  logic                 req1_rvalid_o;
  logic [DATAWIDTH-1:0] req1_rdata_o;
  logic                 req1_err_o;

  logic                 mem_ena_o;
  logic [ADDRWIDTH-1:0] mem_addr_o;
  logic                 mem_wena_o;
  logic [DATAWIDTH-1:0] mem_wdata_o;
  logic [DATAWIDTH-1:0] mem_rdata_i;
  logic                 mem_err_i;

  modport slave (
    input  req0_ena_i, req0_addr_i, req0_wena_i, req0_wdata_i, req0_lock_i,
    output req0_gnt_o, req0_rvalid_o, req0_rdata_o, req0_err_o,
    input  req1_ena_i, req1_addr_i, req1_wena_i, req1_wdata_i, req1_lock_i,
    output req1_gnt_o, req1_rvalid_o, req1_rdata_o, req1_err_o,
    output mem_ena_o, mem_addr_o, mem_wena_o, mem_wdata_o,
    input  mem_rdata_i, mem_err_i
  );

  modport master (
    output req0_ena_i, req0_addr_i, req0_wena_i, req0_wdata_i, req0_lock_i,
    input  req0_gnt_o, req0_rvalid_o, req0_rdata_o, req0_err_o,
    output req1_ena_i, req1_addr_i, req1_wena_i, req1_wdata_i, req1_lock_i,
    input  req1_gnt_o, req1_rvalid_o, req1_rdata_o, req1_err_o,
    input  mem_ena_o, mem_addr_o, mem_wena_o, mem_wdata_o,
    output mem_rdata_i, mem_err_i
  );
endinterface

// File: rtl/regf_mem_arb.sv
// Two-requester round-robin arbiter with bounded lock onto a single regf port.
// Grant is combinational; command and response stages give a fixed 3-cycle latency.
module regf_mem_arb #(
  parameter int          ADDRWIDTH = 13,
  parameter int          DATAWIDTH = 32,
  parameter int unsigned LOCKMAX   = 4
) (
  input logic           main_clk_i,
  input logic           main_rst_a_i,
  regf_mem_arb_if.slave regf_bus
);
  localparam logic [3:0] LOCK_LIMIT = 4'(LOCKMAX);

  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  lock_state_t state, state_nxt;
  logic        last, last_nxt;
  logic        owner, owner_nxt;
  logic        idle, idle_nxt;
  logic [3:0]  lockcnt, lockcnt_nxt;

  logic [1:0]  ena, lock;
  logic        gnt_any, gnt_id;

  logic                 mem_ena, mem_wena, cmd_id;
  logic [ADDRWIDTH-1:0] mem_addr;
  logic [DATAWIDTH-1:0] mem_wdata;
  logic                 acc_valid, acc_id, acc_wena;
  logic                 rsp_valid, rsp_id, rsp_err;
  logic [DATAWIDTH-1:0] rsp_rdata;
  logic                 rsp0, rsp1;

  assign ena  = {regf_bus.req1_ena_i, regf_bus.req0_ena_i};
  assign lock = {regf_bus.req1_lock_i, regf_bus.req0_lock_i};

  always_ff @(posedge main_clk_i or posedge main_rst_a_i) begin
    if (main_rst_a_i) begin
      state   <= UNLOCKED;
      last    <= 1'b1;
      owner   <= 1'b0;
      idle    <= 1'b0;
      lockcnt <= '0;
    end else begin
      state   <= state_nxt;
      last    <= last_nxt;
      owner   <= owner_nxt;
      idle    <= idle_nxt;
      lockcnt <= lockcnt_nxt;
    end
  end

  always_comb begin
    gnt_any     = 1'b0;
    gnt_id      = 1'b0;
    state_nxt   = state;
    last_nxt    = last;
    owner_nxt   = owner;
    idle_nxt    = idle;
    lockcnt_nxt = lockcnt;

    case (state)
      UNLOCKED: begin
        if (ena[0] && ena[1]) begin
          gnt_any = 1'b1;
          gnt_id  = ~last;
        end else if (ena != 2'b00) begin
          gnt_any = 1'b1;
          gnt_id  = ena[1];
        end
      end
      LOCKED: begin
        if (ena[owner]) begin
          gnt_any = 1'b1;
          gnt_id  = owner;
        end
      end
      default: ;
    endcase

    if (gnt_any) begin
      last_nxt = gnt_id;
      idle_nxt = 1'b0;
      // The grant that reaches LOCKMAX still goes out but closes the lock.
      if (lock[gnt_id] && (lockcnt + 4'd1) != LOCK_LIMIT) begin
        state_nxt   = LOCKED;
        owner_nxt   = gnt_id;
        lockcnt_nxt = lockcnt + 4'd1;
      end else begin
        state_nxt   = UNLOCKED;
        lockcnt_nxt = '0;
      end
    end else if (state == LOCKED) begin
      if (idle) begin
        state_nxt   = UNLOCKED;
        lockcnt_nxt = '0;
        idle_nxt    = 1'b0;
      end else begin
        idle_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge main_clk_i or posedge main_rst_a_i) begin
    if (main_rst_a_i) begin
      mem_ena   <= 1'b0;
      mem_wena  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cmd_id    <= 1'b0;
    end else begin
      mem_ena <= gnt_any;
      if (gnt_any) begin
        cmd_id    <= gnt_id;
        mem_addr  <= gnt_id ? regf_bus.req1_addr_i  : regf_bus.req0_addr_i;
        mem_wena  <= gnt_id ? regf_bus.req1_wena_i  : regf_bus.req0_wena_i;
        mem_wdata <= gnt_id ? regf_bus.req1_wdata_i : regf_bus.req0_wdata_i;
      end
    end
  end

  always_ff @(posedge main_clk_i or posedge main_rst_a_i) begin
    if (main_rst_a_i) begin
      acc_valid <= 1'b0;
      acc_id    <= 1'b0;
      acc_wena  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      acc_valid <= mem_ena;
      acc_id    <= cmd_id;
      acc_wena  <= mem_wena;
      rsp_valid <= acc_valid;
      if (acc_valid) begin
        rsp_id    <= acc_id;
        rsp_err   <= regf_bus.mem_err_i;
        rsp_rdata <= acc_wena ? '0 : regf_bus.mem_rdata_i;
      end
    end
  end

  assign rsp0 = rsp_valid & ~rsp_id;
  assign rsp1 = rsp_valid &  rsp_id;

  // Gate grants during reset so every output reads 0 while it is held.
  assign regf_bus.req0_gnt_o    = gnt_any & ~gnt_id & ~main_rst_a_i;
  assign regf_bus.req1_gnt_o    = gnt_any &  gnt_id & ~main_rst_a_i;
  assign regf_bus.req0_rvalid_o = rsp0;
  assign regf_bus.req1_rvalid_o = rsp1;
  assign regf_bus.req0_rdata_o  = rsp0 ? rsp_rdata : '0;
  assign regf_bus.req1_rdata_o  = rsp1 ? rsp_rdata : '0;
  assign regf_bus.req0_err_o    = rsp0 & rsp_err;
  assign regf_bus.req1_err_o    = rsp1 & rsp_err;

  assign regf_bus.mem_ena_o   = mem_ena;
  assign regf_bus.mem_addr_o  = mem_addr;
  assign regf_bus.mem_wena_o  = mem_wena;
  assign regf_bus.mem_wdata_o = mem_wdata;
endmodule
